// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) producing an 8-digit packed BCD word.
// Values above 99,999,999 bypass the shifter and saturate the display to all nines.
module bin2bcd_seq #(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [31:0]      nums,
    output logic             nums_valid,
    output logic             ovf
);

    localparam int              CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [31:0]     MAX_DEC  = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [31:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [31:0]        nums_q, nums_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [31:0]        bcd_adj;
    logic [31:0]        bin_wide;

    // Each nibble corrected independently; no carry crosses a digit boundary.
    function automatic logic [31:0] add3_nibbles(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj  = add3_nibbles(bcd_q);
    assign bin_wide = 32'(bin);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        nums_d     = nums_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin;
                    bcd_d      = 32'h0;
                    cnt_d      = '0;
                    ovf_pend_d = (bin_wide > MAX_DEC);
                    state_d    = (bin_wide > MAX_DEC) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                nums_d  = ovf_pend_q ? 32'h9999_9999 : bcd_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= 32'h0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            nums_q     <= 32'h0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            nums_q     <= nums_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign nums       = nums_q;
    assign nums_valid = valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 27-, 4- and 1-bit builds checked against a decimal-digit reference.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4, start1;
    logic [26:0] bin;
    logic [3:0]  bin4;
    logic        bin1;
    logic        busy, done, nums_valid, ovf;
    logic [31:0] nums;
    logic        busy4, done4, nums_valid4, ovf4;
    logic [31:0] nums4;
    logic        busy1, done1, nums_valid1, ovf1;
    logic [31:0] nums1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(27)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
        .nums(nums), .nums_valid(nums_valid), .ovf(ovf)
    );
    bin2bcd_seq #(.BIN_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4), .busy(busy4), .done(done4),
        .nums(nums4), .nums_valid(nums_valid4), .ovf(ovf4)
    );
    bin2bcd_seq #(.BIN_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin(bin1), .busy(busy1), .done(done1),
        .nums(nums1), .nums_valid(nums_valid1), .ovf(ovf1)
    );

    // Reference: decimal digits of the value, saturating above eight digits.
    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        r = 32'h0;
        x = v;
        if (v > 64'd99_999_999) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_lat(input longint unsigned v, input int w);
        return (v > 64'd99_999_999) ? 1 : w + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion on the selected build; returns what was observed.
    task automatic do_conv(input int w, input longint unsigned v, output int lat,
                           output logic [31:0] got_nums, output logic got_ovf,
                           output logic got_valid, output logic done_after);
        logic d;
        case (w)
            4:       begin start4 = 1'b1; bin4 = 4'(v);  end
            1:       begin start1 = 1'b1; bin1 = 1'(v);  end
            default: begin start  = 1'b1; bin  = 27'(v); end
        endcase
        tick;
        start = 1'b0; start4 = 1'b0; start1 = 1'b0;
        bin = 27'($urandom); bin4 = 4'($urandom); bin1 = 1'($urandom);
        lat = -1; got_nums = 32'h0; got_ovf = 1'b0; got_valid = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            tick;
            d = (w == 4) ? done4 : (w == 1) ? done1 : done;
            if (d === 1'b1) begin
                lat       = c;
                got_nums  = (w == 4) ? nums4 : (w == 1) ? nums1 : nums;
                got_ovf   = (w == 4) ? ovf4 : (w == 1) ? ovf1 : ovf;
                got_valid = (w == 4) ? nums_valid4 : (w == 1) ? nums_valid1 : nums_valid;
                break;
            end
        end
        tick;
        done_after = (w == 4) ? done4 : (w == 1) ? done1 : done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; bin = 27'd12_345_678;
        tick;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_prio_busy: got %b expected 0", busy); end
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (nums !== 32'h0) begin n_err++; $display("FAIL rst_nums: got %h expected 00000000", nums); end
        n_cmp++; if (nums_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", nums_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        n_cmp++; if ({busy4, done4, nums_valid4, busy1, done1, nums_valid1} !== 6'b0) begin
            n_err++; $display("FAIL rst_small: got %b expected 000000", {busy4, done4, nums_valid4, busy1, done1, nums_valid1});
        end
    endtask

    task automatic test_known;
        longint unsigned vals[5] = '{12_345_678, 0, 99_999_999, 100_000_000, 87_654_321};
        int lat; logic [31:0] gn; logic go, gv, da;
        for (int i = 0; i < 5; i++) begin
            do_conv(27, vals[i], lat, gn, go, gv, da);
            n_cmp++; if (lat !== exp_lat(vals[i], 27)) begin n_err++; $display("FAIL known_lat[%0d]: got %0d expected %0d", i, lat, exp_lat(vals[i], 27)); end
            n_cmp++; if (gn !== ref_bcd(vals[i])) begin n_err++; $display("FAIL known_nums[%0d]: got %h expected %h", i, gn, ref_bcd(vals[i])); end
            n_cmp++; if (go !== (vals[i] > 99_999_999)) begin n_err++; $display("FAIL known_ovf[%0d]: got %b", i, go); end
            n_cmp++; if (gv !== 1'b1) begin n_err++; $display("FAIL known_valid[%0d]: got %b expected 1", i, gv); end
            n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL known_pulse[%0d]: got %b expected 0", i, da); end
        end
    endtask

    task automatic test_hold;
        int lat; logic [31:0] gn; logic go, gv, da;
        do_conv(27, 100_000_000, lat, gn, go, gv, da);
        start = 1'b1; bin = 27'd87_654_321;
        tick;
        start = 1'b1; bin = 27'd11_111_111;
        for (int c = 0; c < 5; c++) tick;
        start = 1'b0;
        n_cmp++; if ({busy, done, ovf, nums} !== {3'b101, 32'h9999_9999}) begin
            n_err++; $display("FAIL hold_mid: got busy=%b done=%b ovf=%b nums=%h expected 1 0 1 99999999", busy, done, ovf, nums);
        end
        lat = -1;
        for (int c = 6; c <= 64; c++) begin
            tick;
            if (done === 1'b1) begin lat = c; break; end
        end
        n_cmp++; if (lat !== 28 || nums !== 32'h8765_4321 || ovf !== 1'b0) begin
            n_err++; $display("FAIL hold_result: got lat=%0d nums=%h ovf=%b expected 28 87654321 0", lat, nums, ovf);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int free_at = 0, done_edge = -1, last_done = -1;
        logic [31:0] exp_nums = 32'h0;
        logic [26:0] v;
        for (int cyc = 0; cyc < 190; cyc++) begin
            v = 27'($urandom_range(99_999_999, 0));
            start = (cyc < 150);
            bin = v;
            if (start && cyc >= free_at) begin
                done_edge = cyc + 28;
                free_at   = done_edge + 1;
                exp_nums  = ref_bcd(v);
            end
            tick;
            n_cmp++; if (done !== (cyc == done_edge)) begin
                n_err++; $display("FAIL b2b_done@%0d: got %b expected %b", cyc, done, cyc == done_edge);
            end
            if (cyc == done_edge) begin
                n_cmp++; if (nums !== exp_nums || ovf !== 1'b0) begin
                    n_err++; $display("FAIL b2b_nums@%0d: got %h ovf=%b expected %h", cyc, nums, ovf, exp_nums);
                end
            end
            if (done === 1'b1) begin
                if (last_done >= 0) begin
                    n_cmp++; if (cyc - last_done !== 29) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 29", cyc - last_done); end
                end
                last_done = cyc;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic saw_done = 1'b0;
        int lat; logic [31:0] gn; logic go, gv, da;
        start = 1'b1; bin = 27'd12_345_678;
        tick;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin tick; if (done === 1'b1) saw_done = 1'b1; end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if ({done, busy, nums_valid, ovf, nums} !== 36'h0) begin
            n_err++; $display("FAIL rstmid_state: got done=%b busy=%b valid=%b ovf=%b nums=%h expected all 0", done, busy, nums_valid, ovf, nums);
        end
        for (int c = 0; c < 35; c++) begin tick; if (done === 1'b1) saw_done = 1'b1; end
        n_cmp++; if (saw_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_nodone: got done_seen=%b busy=%b expected 0 0", saw_done, busy);
        end
        do_conv(27, 12_345_678, lat, gn, go, gv, da);
        n_cmp++; if (lat !== 28 || gn !== 32'h1234_5678 || gv !== 1'b1) begin
            n_err++; $display("FAIL rstmid_restart: got lat=%0d nums=%h valid=%b expected 28 12345678 1", lat, gn, gv);
        end
    endtask

    task automatic test_random;
        longint unsigned v;
        int lat; logic [31:0] gn; logic go, gv, da;
        for (int i = 0; i < 400; i++) begin
            case (i % 8)
                0:       v = $urandom_range(134_217_727, 100_000_000);
                1:       v = $urandom_range(100_000_002, 99_999_997);
                2:       v = $urandom_range(9_999, 0);
                default: v = $urandom_range(134_217_727, 0);
            endcase
            do_conv(27, v, lat, gn, go, gv, da);
            n_cmp++; if (lat !== exp_lat(v, 27) || da !== 1'b0) begin
                n_err++; $display("FAIL rand_timing v=%0d: got lat=%0d after=%b expected %0d 0", v, lat, da, exp_lat(v, 27));
            end
            n_cmp++; if (gn !== ref_bcd(v) || go !== (v > 99_999_999)) begin
                n_err++; $display("FAIL rand_value v=%0d: got %h ovf=%b expected %h", v, gn, go, ref_bcd(v));
            end
        end
    endtask

    task automatic test_small_widths;
        int lat; logic [31:0] gn; logic go, gv, da;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 16; v++) begin
                do_conv(4, longint'(v), lat, gn, go, gv, da);
                n_cmp++; if (lat !== 5 || da !== 1'b0 || gv !== 1'b1) begin
                    n_err++; $display("FAIL w4_timing v=%0d: got lat=%0d after=%b valid=%b expected 5 0 1", v, lat, da, gv);
                end
                n_cmp++; if (gn !== ref_bcd(longint'(v)) || go !== 1'b0) begin
                    n_err++; $display("FAIL w4_value v=%0d: got %h ovf=%b expected %h", v, gn, go, ref_bcd(longint'(v)));
                end
            end
            for (int v = 0; v < 2; v++) begin
                do_conv(1, longint'(v), lat, gn, go, gv, da);
                n_cmp++; if (lat !== 2 || da !== 1'b0 || gv !== 1'b1) begin
                    n_err++; $display("FAIL w1_timing v=%0d: got lat=%0d after=%b valid=%b expected 2 0 1", v, lat, da, gv);
                end
                n_cmp++; if (gn !== ref_bcd(longint'(v)) || go !== 1'b0) begin
                    n_err++; $display("FAIL w1_value v=%0d: got %h ovf=%b expected %h", v, gn, go, ref_bcd(longint'(v)));
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; start4 = 1'b0; start1 = 1'b0;
        bin = '0; bin4 = '0; bin1 = 1'b0;
        test_reset;
        test_known;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_small_widths;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
